// File: rtl/md_sequencer.sv
// Execute-stage sequencer for the multi-cycle multiplier/divider: detects mul/div in DX,
// starts the unit, stalls the front of the pipeline and injects the result into XM.
module md_sequencer #(
   parameter int TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dx_insn,
   input  logic        dx_valid,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   input  logic        md_result_rdy,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   output logic        ctrl_mult,
   output logic        ctrl_div,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   output logic        stall,
   output logic        xm_inject,
   output logic [31:0] md_out,
   output logic        md_ovf,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [4:0] op_mul   = 5'b00110;
   localparam logic [4:0] op_div   = 5'b00111;
   localparam logic [5:0] cnt_last = 6'(TIMEOUT - 1);

   state_t     state;
   state_t     state_next;
   logic [5:0] cnt;
   logic       kind_div;
   logic       is_md;
   logic       load_ops;
   logic       load_res;
   logic       load_timeout;

   // Only opcode and ALU-op fields take part in the decode.
   logic unused_insn;
   assign unused_insn = ^{dx_insn[26:7], dx_insn[1:0]};

   assign is_md = dx_valid && (dx_insn[31:27] == 5'b00000) &&
                  ((dx_insn[6:2] == op_mul) || (dx_insn[6:2] == op_div));

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      stall        = 1'b0;
      ctrl_mult    = 1'b0;
      ctrl_div     = 1'b0;
      xm_inject    = 1'b0;
      load_ops     = 1'b0;
      load_res     = 1'b0;
      load_timeout = 1'b0;

      case (state)
         IDLE: begin
            stall = is_md;
            if (is_md && !flush) begin
               load_ops   = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            stall      = 1'b1;
            ctrl_mult  = !kind_div && !flush;
            ctrl_div   = kind_div && !flush;
            state_next = flush ? IDLE : RUN;
         end
         RUN: begin
            stall = 1'b1;
            if (flush) begin
               state_next = IDLE;
            end else if (md_result_rdy) begin
               load_res   = 1'b1;
               state_next = DONE;
            end else if (cnt == cnt_last) begin
               load_timeout = 1'b1;
               state_next   = DONE;
            end
         end
         DONE: begin
            xm_inject  = !flush;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      busy = (state != IDLE);

      // Reset low masks every control output in the same cycle, before the state is cleared.
      if (!reset) begin
         stall     = 1'b0;
         ctrl_mult = 1'b0;
         ctrl_div  = 1'b0;
         xm_inject = 1'b0;
         busy      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         kind_div <= 1'b0;
         md_a     <= '0;
         md_b     <= '0;
         md_out   <= '0;
         md_ovf   <= 1'b0;
      end else begin
         state <= state_next;

         if (state == ISSUE) begin
            cnt <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
         end

         if (load_ops) begin
            md_a     <= op_a;
            md_b     <= op_b;
            kind_div <= (dx_insn[6:2] == op_div);
         end

         // Ready has priority over timeout when both land in the same cycle.
         if (load_res) begin
            md_out <= md_result;
            md_ovf <= md_exception;
         end else if (load_timeout) begin
            md_out <= '0;
            md_ovf <= 1'b1;
         end
      end
   end

   a_one_start : assert property (@(posedge clock) !(ctrl_mult && ctrl_div));
   a_issue_once : assert property (@(posedge clock) disable iff (!reset)
                                   (state == ISSUE) |=> (state != ISSUE));

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed operations with a result scoreboard
// that is filled when the bench plays the multdiv unit and drained on each XM inject.
module tb_md_sequencer;

   localparam int TIMEOUT = 40;

   logic        clock;
   logic        reset;
   logic [31:0] dx_insn;
   logic        dx_valid;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        md_result_rdy;
   logic [31:0] md_result;
   logic        md_exception;
   logic        ctrl_mult;
   logic        ctrl_div;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        stall;
   logic        xm_inject;
   logic [31:0] md_out;
   logic        md_ovf;
   logic        busy;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [32:0] sb[$];

   md_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .clock         (clock),
      .reset         (reset),
      .dx_insn       (dx_insn),
      .dx_valid      (dx_valid),
      .op_a          (op_a),
      .op_b          (op_b),
      .flush         (flush),
      .md_result_rdy (md_result_rdy),
      .md_result     (md_result),
      .md_exception  (md_exception),
      .ctrl_mult     (ctrl_mult),
      .ctrl_div      (ctrl_div),
      .md_a          (md_a),
      .md_b          (md_b),
      .stall         (stall),
      .xm_inject     (xm_inject),
      .md_out        (md_out),
      .md_ovf        (md_ovf),
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard drain: every inject must match the oldest outstanding result.
   always @(negedge clock) begin
      logic [32:0] exp;
      if (xm_inject) begin
         check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("sb_md_out", 64'(md_out), 64'(exp[31:0]));
            check("sb_md_ovf", 64'(md_ovf), 64'(exp[32]));
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] make_insn(input logic [4:0] alu_op);
      logic [31:0] ins;
      ins        = '0;
      ins[26:7]  = 20'($urandom);
      ins[6:2]   = alu_op;
      ins[1:0]   = 2'($urandom);
      return ins;
   endfunction

   // Runs one mul/div from the detect cycle through DONE (or an abort at RUN cycle abort_k).
   // rdy_k < 0 means the unit never answers.
   task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input int rdy_k, input int abort_k, input bit abort_rst);
      logic [31:0] res;
      logic        exc;
      int          stalls;
      int          t0;
      int          exp_len;
      bit          got_rdy;

      if (is_div) begin
         exc = (b == 0);
         res = exc ? 32'h0 : 32'($signed(a) / $signed(b));
      end else begin
         exc = 1'b0;
         res = a * b;
      end
      got_rdy = (rdy_k >= 0) && (rdy_k < TIMEOUT);
      exp_len = got_rdy ? rdy_k + 3 : TIMEOUT + 2;

      dx_insn       = make_insn(is_div ? 5'b00111 : 5'b00110);
      dx_valid      = 1'b1;
      op_a          = a;
      op_b          = b;
      flush         = 1'b0;
      md_result_rdy = 1'b0;
      #1;
      t0 = cyc;
      check("detect_busy", 64'(busy), 64'd0);
      check("detect_stall", 64'(stall), 64'd1);
      stalls = 1;

      next_cycle();
      op_a          = ~a;
      op_b          = ~b;
      md_result_rdy = 1'b1;
      md_result     = 32'hdead_beef;
      md_exception  = 1'b1;
      #1;
      check("issue_mult", 64'(ctrl_mult), 64'(!is_div));
      check("issue_div", 64'(ctrl_div), 64'(is_div));
      check("issue_stall", 64'(stall), 64'd1);
      check("issue_busy", 64'(busy), 64'd1);
      stalls += int'(stall);

      for (int k = 0; k < TIMEOUT; k++) begin
         next_cycle();
         md_result_rdy = (k == rdy_k);
         md_result     = res;
         md_exception  = exc;
         if (k == abort_k) begin
            md_result_rdy = 1'b0;
            if (abort_rst) reset = 1'b0;
            else           flush = 1'b1;
            #1;
            check("abort_stall", 64'(stall), 64'(!abort_rst));
            check("abort_busy", 64'(busy), 64'(!abort_rst));
            check("abort_ctrl", 64'({ctrl_mult, ctrl_div}), 64'd0);
            check("abort_inject", 64'(xm_inject), 64'd0);
            next_cycle();
            reset    = 1'b1;
            flush    = 1'b0;
            dx_valid = 1'b0;
            #1;
            check("post_abort_busy", 64'(busy), 64'd0);
            check("post_abort_stall", 64'(stall), 64'd0);
            if (abort_rst) begin
               check("post_rst_md_a", 64'(md_a), 64'd0);
               check("post_rst_md_out", 64'({md_ovf, md_out}), 64'd0);
            end
            md_result_rdy = 1'b1;
            next_cycle();
            md_result_rdy = 1'b0;
            #1;
            check("late_rdy_busy", 64'(busy), 64'd0);
            check("late_rdy_inject", 64'(xm_inject), 64'd0);
            next_cycle();
            return;
         end
         #1;
         check("run_md_ab", {md_a, md_b}, {a, b});
         check("run_stall", 64'(stall), 64'd1);
         check("run_ctrl", 64'({ctrl_mult, ctrl_div}), 64'd0);
         stalls += int'(stall);
         if (k == rdy_k || k == TIMEOUT - 1) begin
            sb.push_back((k == rdy_k) ? {exc, res} : {1'b1, 32'h0});
            break;
         end
      end

      next_cycle();
      md_result_rdy = 1'b0;
      #1;
      check("done_inject", 64'(xm_inject), 64'd1);
      check("done_stall", 64'(stall), 64'd0);
      check("done_busy", 64'(busy), 64'd1);
      check("done_result", 64'({md_ovf, md_out}), got_rdy ? 64'({exc, res}) : 64'({1'b1, 32'h0}));
      check("done_cycle", 64'(cyc - t0), 64'(exp_len));
      check("stall_len", 64'(stalls), 64'(exp_len));

      next_cycle();
      dx_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      dx_insn       = make_insn(5'b00110);
      dx_valid      = 1'b1;
      op_a          = 32'h1111_1111;
      op_b          = 32'h2222_2222;
      flush         = 1'b0;
      md_result_rdy = 1'b1;
      md_result     = 32'h5555_5555;
      md_exception  = 1'b1;

      // Reset: outputs forced low even with a mul sitting in DX.
      next_cycle();
      next_cycle();
      check("rst_ctrl_out", 64'({stall, ctrl_mult, ctrl_div, xm_inject, busy}), 64'd0);
      check("rst_regs", {md_a, md_b}, 64'd0);
      check("rst_result", 64'({md_ovf, md_out}), 64'd0);
      dx_valid      = 1'b0;
      md_result_rdy = 1'b0;
      reset         = 1'b1;
      next_cycle();

      // Non-md instructions, bubbles and a flushed detect never start an operation.
      for (int i = 0; i < 4; i++) begin
         dx_valid = (i != 1);
         dx_insn  = make_insn((i == 0) ? 5'b00000 : (i == 2) ? 5'b00101 : 5'b00110);
         if (i == 3) dx_insn[31:27] = 5'b00101;
         if (i == 1) dx_insn = make_insn(5'b00111);
         #1;
         check("no_md_stall", 64'(stall), 64'd0);
         next_cycle();
         check("no_md_busy", 64'(busy), 64'd0);
      end
      dx_insn  = make_insn(5'b00111);
      dx_valid = 1'b1;
      flush    = 1'b1;
      #1;
      check("flush_idle_stall", 64'(stall), 64'd1);
      next_cycle();
      flush    = 1'b0;
      dx_valid = 1'b0;
      #1;
      check("flush_idle_busy", 64'(busy), 64'd0);
      next_cycle();

      // mul 7 * -3 answered in RUN cycle 15.
      do_op(1'b0, 32'd7, -32'sd3, 15, -1, 1'b0);
      // div by zero, unit never answers: timeout.
      do_op(1'b1, 32'd9, 32'd0, -1, -1, 1'b0);
      // flush in RUN cycle 5.
      do_op(1'b0, 32'd11, 32'd13, 20, 5, 1'b0);
      // back-to-back mul then div.
      do_op(1'b0, 32'd12345, -32'sd2, 3, -1, 1'b0);
      do_op(1'b1, 32'd100, 32'd7, 0, -1, 1'b0);
      // reset low in RUN cycle 3.
      do_op(1'b1, 32'd50, 32'd5, 10, 3, 1'b1);
      // ready coincides with the timeout count.
      do_op(1'b0, 32'h0001_0003, 32'h0000_0101, TIMEOUT - 1, -1, 1'b0);
      // div with a ready divide-by-zero exception.
      do_op(1'b1, -32'sd77, 32'd0, 2, -1, 1'b0);
      // one-cycle RUN: ready immediately.
      do_op(1'b1, -32'sd77, 32'd4, 0, -1, 1'b0);

      next_cycle();
      next_cycle();
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Execute-stage controller that sequences the multi-cycle multiplier/divider for the 5-stage pipeline.

- Detects `mul`/`div` in the DX latch and latches their operands.
- Issues a one-cycle start pulse to the multdiv unit.
- Holds PC, FD and DX stalled until the unit reports ready or a timeout counter expires.
- Injects the result and exception flag into the XM latch in place of the ALU output.

## Interface
Parameters:
- `TIMEOUT`, default 40: maximum RUN-state cycles before forced completion. Legal range 2..63.

Ports:
- `clock`: input, 1 bit. Master clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-low. Sampled on the rising edge of `clock`.
- `dx_insn`: input, 32 bits. Instruction currently held in the DX latch.
- `dx_valid`: input, 1 bit. DX holds a real instruction (0 = bubble).
- `op_a`, `op_b`: inputs, 32 bits each. Bypassed ALU operands for the DX instruction.
- `flush`: input, 1 bit. Pipeline flush (taken branch/jump); aborts any operation in progress.
- `md_result_rdy`: input, 1 bit. Multdiv unit result valid.
- `md_result`: input, 32 bits. Multdiv result.
- `md_exception`: input, 1 bit. Multdiv overflow / divide-by-zero.
- `ctrl_mult`, `ctrl_div`: outputs, 1 bit each. One-cycle start pulses to the multdiv unit.
- `md_a`, `md_b`: outputs, 32 bits each. Registered operands to the multdiv unit.
- `stall`: output, 1 bit. Freeze the PC, FD and DX latches.
- `xm_inject`: output, 1 bit. XM latch captures `md_out`/`md_ovf` instead of the ALU output and overflow.
- `md_out`: output, 32 bits. Captured result.
- `md_ovf`: output, 1 bit. Captured exception.
- `busy`: output, 1 bit. State is not IDLE.

## Operation
Decode:
- `is_md = dx_valid & (dx_insn[31:27]==5'b00000) & (dx_insn[6:2]==5'b00110 | dx_insn[6:2]==5'b00111)`.
- ALU op `00110` = mul, `00111` = div.

States: IDLE, ISSUE, RUN, DONE.

- **IDLE**
  - `stall = is_md` (combinational).
  - On the edge with `is_md & ~flush`: capture `op_a`→`md_a`, `op_b`→`md_b`, and the kind bit (mul/div). Go to ISSUE.
  - Otherwise remain in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `ctrl_mult` = kind is mul; `ctrl_div` = kind is div.
  - `stall = 1`.
  - Clear the 6-bit cycle counter to 0. Go to RUN.
- **RUN**
  - `stall = 1`. Counter increments every cycle.
  - `md_result_rdy` = 1: capture `md_result`→`md_out` and `md_exception`→`md_ovf`. Go to DONE.
  - Else, counter == `TIMEOUT-1`: `md_out = 0`, `md_ovf = 1`. Go to DONE.
  - Ready and timeout in the same cycle: ready wins.
- **DONE** (exactly 1 cycle)
  - `stall = 0`, `xm_inject = 1`. The instruction advances DX→XM carrying `md_out`/`md_ovf`.
  - Go to IDLE unconditionally. This prevents re-triggering on the same instruction.

Boundary rules:
- `flush` in ISSUE, RUN or DONE:
  - Next state IDLE; `ctrl_*` and `xm_inject` forced to 0 that cycle.
  - `md_out`/`md_ovf` are not updated.
  - `stall` follows the current state's rule for that cycle.
- `md_result_rdy` is ignored outside RUN, including a stale ready during ISSUE.
- Back-to-back mul/div instructions: the second is detected in the IDLE cycle immediately after DONE, so there is no lost cycle.
- `md_a`/`md_b` hold their values through RUN, even if `op_a`/`op_b` change.

## Timing
Reset:
- While `reset`=0 at the edge: state IDLE, counter 0, `md_a`/`md_b`/`md_out` = 0, `md_ovf` = 0.
- While `reset` is low, `stall`, `ctrl_mult`, `ctrl_div`, `xm_inject` and `busy` are forced to 0 combinationally.
- Reset mid-operation abandons the operation; no inject occurs.

Stall length:
- Detect cycle T (IDLE, `stall` high), ISSUE at T+1, RUN from T+2.
- Ready in RUN cycle k (k=0 at T+2) gives DONE at T+3+k.
- Total `stall`-high cycles = k+3.
- Timeout gives DONE at T+2+`TIMEOUT`, so `stall` is high for `TIMEOUT`+2 cycles.

Other timing:
- `ctrl_mult`/`ctrl_div` are high for exactly one cycle per operation and are never both high.
- `busy` = state ≠ IDLE (registered state decode).

## Test plan
- **mul with ready at RUN cycle 15:** DX = mul, `op_a`=7, `op_b`=−3, unit returns −21 → `ctrl_mult` pulses once at T+1; `stall` high 18 cycles; `xm_inject` at T+18 with `md_out`=0xFFFFFFEB, `md_ovf`=0.
- **div timeout:** div, `op_b`=0, unit never ready, `TIMEOUT`=40 → `ctrl_div` pulse; DONE at T+42 with `md_out`=0, `md_ovf`=1.
- **flush in RUN:** flush asserted in RUN cycle 5 → next cycle IDLE, `stall`=0, no `xm_inject`; a later ready pulse is ignored.
- **Back-to-back:** mul then div in consecutive instructions → two separate start pulses; the second detect occurs the cycle after the first DONE; both results injected in order.
- **Reset low in RUN, plus ready/timeout collision:** reset low during RUN → all outputs 0 the same cycle, state IDLE after the edge. Separately, ready coinciding with counter = `TIMEOUT-1` → `md_out`=`md_result`, `md_ovf`=`md_exception`.
